// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter and cycle sequencer for an external async 16-bit SRAM.
// Strobes are registered from the next-state decode, so pads change cleanly on the clock edge.
module sram_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int RD_WAIT  = 2,
  parameter int WR_PULSE = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [15:0]       req0_wdata,
  input  logic [1:0]        req0_be,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [15:0]       req1_wdata,
  input  logic [1:0]        req1_be,
  output logic              rsp0_valid,
  output logic [15:0]       rsp0_rdata,
  output logic              rsp1_valid,
  output logic [15:0]       rsp1_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dout,
  output logic              sram_drive,
  input  logic [15:0]       sram_din,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD, ST_RD_DONE, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD
  } state_t;

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);

  state_t             r_state;
  state_t             w_state_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic               r_prio;
  logic               r_port;
  logic [ADDR_W-1:0]  r_addr;
  logic [15:0]        r_dout;
  logic               r_drive;
  logic               r_ce_n, r_we_n, r_oe_n, r_lb_n, r_ub_n;
  logic               r_rsp0_valid, r_rsp1_valid;
  logic [15:0]        r_rdata0, r_rdata1;

  logic               w_idle;
  logic               w_gnt;
  logic               w_accept;
  logic               w_cnt_zero;
  logic               w_rd_last;
  logic               w_sel_write;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [15:0]        w_sel_wdata;
  logic [1:0]         w_sel_be;
  logic               w_ce_n_nx, w_we_n_nx, w_oe_n_nx, w_drive_nx, w_lb_n_nx, w_ub_n_nx;

  // With both ports pending the priority port wins; otherwise the lone requester does.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_gnt       = (req0_valid & req1_valid) ? r_prio : req1_valid;
  assign req0_ready  = w_idle & ~RESET & req0_valid & ~w_gnt;
  assign req1_ready  = w_idle & ~RESET & req1_valid & w_gnt;
  assign w_accept    = req0_ready | req1_ready;

  assign w_sel_write = w_gnt ? req1_write : req0_write;
  assign w_sel_addr  = w_gnt ? req1_addr  : req0_addr;
  assign w_sel_wdata = w_gnt ? req1_wdata : req0_wdata;
  assign w_sel_be    = w_gnt ? req1_be    : req0_be;

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_rd_last   = (r_state == ST_RD) & w_cnt_zero;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nx = w_sel_write ? ST_WR_SETUP : ST_RD;
          w_cnt_nx   = RD_LOAD;
        end
      end
      ST_RD: begin
        if (w_cnt_zero) w_state_nx = ST_RD_DONE;
        else            w_cnt_nx   = r_cnt - 1'b1;
      end
      ST_RD_DONE:  w_state_nx = ST_IDLE;
      ST_WR_SETUP: begin
        w_state_nx = ST_WR_PULSE;
        w_cnt_nx   = WR_LOAD;
      end
      ST_WR_PULSE: begin
        if (w_cnt_zero) w_state_nx = ST_WR_HOLD;
        else            w_cnt_nx   = r_cnt - 1'b1;
      end
      ST_WR_HOLD:  w_state_nx = ST_IDLE;
      default:     w_state_nx = ST_IDLE;
    endcase

    w_ce_n_nx  = (w_state_nx == ST_IDLE);
    w_oe_n_nx  = (w_state_nx != ST_RD);
    w_we_n_nx  = (w_state_nx != ST_WR_PULSE);
    w_drive_nx = (w_state_nx inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});

    // Byte lanes are latched at accept and held until the sequence returns to idle.
    w_lb_n_nx = r_lb_n;
    w_ub_n_nx = r_ub_n;
    if (w_accept) begin
      w_lb_n_nx = ~w_sel_be[0];
      w_ub_n_nx = ~w_sel_be[1];
    end else if (w_state_nx == ST_IDLE) begin
      w_lb_n_nx = 1'b1;
      w_ub_n_nx = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_prio       <= 1'b0;
      r_port       <= 1'b0;
      r_addr       <= '0;
      r_dout       <= '0;
      r_drive      <= 1'b0;
      r_ce_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_lb_n       <= 1'b1;
      r_ub_n       <= 1'b1;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_drive      <= w_drive_nx;
      r_ce_n       <= w_ce_n_nx;
      r_we_n       <= w_we_n_nx;
      r_oe_n       <= w_oe_n_nx;
      r_lb_n       <= w_lb_n_nx;
      r_ub_n       <= w_ub_n_nx;
      if (w_accept) begin
        r_prio <= ~r_prio;
        r_port <= w_gnt;
        r_addr <= w_sel_addr;
        r_dout <= w_sel_wdata;
      end
      // Pad data is sampled on the edge that ends the last OE-low cycle.
      r_rsp0_valid <= w_rd_last & ~r_port;
      r_rsp1_valid <= w_rd_last & r_port;
      if (w_rd_last & ~r_port) r_rdata0 <= sram_din;
      if (w_rd_last & r_port)  r_rdata1 <= sram_din;
    end
  end

  assign sram_addr  = r_addr;
  assign sram_dout  = r_dout;
  assign sram_drive = r_drive;
  assign sram_ce_n  = r_ce_n;
  assign sram_we_n  = r_we_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_lb_n  = r_lb_n;
  assign sram_ub_n  = r_ub_n;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_rdata = r_rdata0;
  assign rsp1_rdata = r_rdata1;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM pad model, grant/prio model, vector table and corner sequences.
module tb_sram_arbiter;
  localparam int ADDR_W   = 18;
  localparam int RD_WAIT  = 2;
  localparam int WR_PULSE = 2;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic req0_valid = 1'b0, req0_write = 1'b0, req1_valid = 1'b0, req1_write = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
  logic [15:0] req0_wdata = '0, req1_wdata = '0;
  logic [1:0] req0_be = '0, req1_be = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_rdata, rsp1_rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0] sram_dout, sram_din;
  logic sram_drive, sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n;

  sram_arbiter #(.ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_be(req0_be),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_be(req1_be),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_drive(sram_drive), .sram_din(sram_din),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Asynchronous SRAM: reads while OE and CE are low, writes enabled bytes while WE is low.
  logic [15:0] mem [0:(1<<ADDR_W)-1];
  assign sram_din = (!sram_oe_n && !sram_ce_n) ? mem[sram_addr] : 16'h0000;
  always @(posedge CLK) begin
    if (!sram_ce_n && !sram_we_n && sram_drive) begin
      if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dout[7:0];
      if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dout[15:8];
    end
  end

  // Grant model: lone requester wins, contention goes to prio, prio flips on every accept.
  int m_prio = 0;
  int acc0 = 0, acc1 = 0;
  int grant_q[$];
  int mon_exp_g;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) m_prio = 0;
    else if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
      mon_exp_g = (req0_valid && req1_valid) ? m_prio : (req1_valid ? 1 : 0);
      chk("grant_port", int'(req1_valid && req1_ready), mon_exp_g);
      chk("single_ready", int'(req0_ready && req1_ready), 0);
      grant_q.push_back(int'(req1_valid && req1_ready));
      if (req1_valid && req1_ready) acc1++; else acc0++;
      m_prio = 1 - m_prio;
    end
  end

  int ncyc = 0, last_oe = -100, rsp_n0 = 0, rsp_n1 = 0;
  logic prev_drive = 1'b0;
  always @(negedge CLK) begin
    ncyc++;
    if (!RESET && !sram_ce_n) begin
      chk("oe_drive_overlap", int'(!sram_oe_n && sram_drive), 0);
      chk("we_without_drive", int'(!sram_we_n && !sram_drive), 0);
    end
    if (!RESET && sram_drive && !prev_drive)
      chk("turnaround_ge2", int'((ncyc - last_oe - 1) >= 2), 1);
    if (!sram_oe_n) last_oe = ncyc;
    prev_drive = sram_drive;
    if (rsp0_valid) rsp_n0++;
    if (rsp1_valid) rsp_n1++;
  end

  task automatic run_op(input logic port, input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be, input logic [15:0] exp_rd);
    int a_before, oe_cnt, we_cnt, drv_cnt, rsp_cnt, rsp_at, first_oe, first_we, idle_at, bad, other_rsp;
    logic [15:0] rd;
    a_before = acc0 + acc1;
    oe_cnt = 0; we_cnt = 0; drv_cnt = 0; rsp_cnt = 0; rsp_at = 0;
    first_oe = 0; first_we = 0; idle_at = 0; bad = 0; other_rsp = 0; rd = '0;
    if (port) begin
      req1_write = wr; req1_addr = addr; req1_wdata = wdata; req1_be = be; req1_valid = 1'b1;
    end else begin
      req0_write = wr; req0_addr = addr; req0_wdata = wdata; req0_be = be; req0_valid = 1'b1;
    end
    for (int w = 0; w < 20 && (acc0 + acc1) == a_before; w++) @(negedge CLK);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("accept", acc0 + acc1 - a_before, 1);
    for (int k = 1; k <= 12; k++) begin
      if (sram_ce_n) begin
        idle_at = k;
        break;
      end
      if (!sram_oe_n) begin oe_cnt++; if (first_oe == 0) first_oe = k; end
      if (!sram_we_n) begin we_cnt++; if (first_we == 0) first_we = k; end
      if (sram_drive) drv_cnt++;
      if (sram_lb_n !== ~be[0] || sram_ub_n !== ~be[1] || sram_addr !== addr ||
          (sram_drive && sram_dout !== wdata)) bad++;
      if (port ? rsp1_valid : rsp0_valid) begin
        rsp_cnt++; rsp_at = k; rd = port ? rsp1_rdata : rsp0_rdata;
      end
      if (port ? rsp0_valid : rsp1_valid) other_rsp++;
      @(negedge CLK);
    end
    chk("addr_be_dout_stable", bad, 0);
    chk("no_rsp_other_port", other_rsp, 0);
    if (wr) begin
      chk("wr_we_low_cycles", we_cnt, WR_PULSE);
      chk("wr_first_we_cycle", first_we, 2);
      chk("wr_drive_cycles", drv_cnt, WR_PULSE + 2);
      chk("wr_idle_cycle", idle_at, WR_PULSE + 3);
      chk("wr_no_oe", oe_cnt, 0);
      chk("wr_no_rsp", rsp_cnt, 0);
    end else begin
      chk("rd_oe_low_cycles", oe_cnt, RD_WAIT);
      chk("rd_first_oe_cycle", first_oe, 1);
      chk("rd_rsp_pulses", rsp_cnt, 1);
      chk("rd_rsp_cycle", rsp_at, RD_WAIT + 1);
      chk("rd_data", int'(rd), int'(exp_rd));
      chk("rd_idle_cycle", idle_at, RD_WAIT + 2);
      chk("rd_no_drive", drv_cnt, 0);
    end
  endtask

  typedef struct packed {
    logic              port;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic [1:0]        be;
    logic [15:0]       exp_rd;
  } vec_t;
  vec_t vecs[12];

  logic [ADDR_W-1:0] raddr[8];
  logic [15:0] refm[8];

  initial begin
    int a0, a1, r0, r1, p_exp, slot;
    logic wr;
    logic [15:0] d;
    logic [1:0] be;

    vecs[0]  = '{1'b1, 1'b1, 18'h00123, 16'hBEEF, 2'b11, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 18'h00123, 16'h0000, 2'b11, 16'hBEEF};
    vecs[2]  = '{1'b0, 1'b1, 18'h3FFFF, 16'h1234, 2'b11, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 18'h3FFFF, 16'hA55A, 2'b01, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 18'h3FFFF, 16'h0000, 2'b11, 16'h125A};
    vecs[5]  = '{1'b0, 1'b1, 18'h00010, 16'hCAFE, 2'b11, 16'h0000};
    vecs[6]  = '{1'b1, 1'b1, 18'h00010, 16'hFFFF, 2'b00, 16'h0000};
    vecs[7]  = '{1'b0, 1'b0, 18'h00010, 16'h0000, 2'b11, 16'hCAFE};
    vecs[8]  = '{1'b1, 1'b1, 18'h00010, 16'h7700, 2'b10, 16'h0000};
    vecs[9]  = '{1'b0, 1'b0, 18'h00010, 16'h0000, 2'b11, 16'h77FE};
    vecs[10] = '{1'b0, 1'b1, 18'h20000, 16'h1111, 2'b11, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 18'h20000, 16'h0000, 2'b11, 16'h1111};

    // Reset state
    #1 RESET = 1'b1;
    req0_valid = 1'b1;
    #1 chk("ready0_in_reset", int'(req0_ready), 0);
    req0_valid = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_strobes", int'({sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n}), 'h1F);
    chk("rst_drive", int'(sram_drive), 0);
    chk("rst_addr", int'(sram_addr), 0);
    chk("rst_dout", int'(sram_dout), 0);
    chk("rst_rsp_valid", int'({rsp0_valid, rsp1_valid}), 0);
    chk("rst_rdata", int'(rsp0_rdata | rsp1_rdata), 0);
    RESET = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_rd);

    // Contention: both ports hold valid for three reads each
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    grant_q.delete();
    a0 = acc0; a1 = acc1; r0 = rsp_n0; r1 = rsp_n1;
    req0_write = 1'b0; req0_addr = 18'h00010; req0_be = 2'b11;
    req1_write = 1'b0; req1_addr = 18'h20000; req1_be = 2'b11;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 100 && ((acc0 - a0) < 3 || (acc1 - a1) < 3); c++) begin
      @(negedge CLK);
      req0_valid = (acc0 - a0) < 3;
      req1_valid = (acc1 - a1) < 3;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("contention_accepts", (acc0 - a0) + (acc1 - a1), 6);
    for (int i = 0; i < 6; i++)
      chk("contention_order", (i < grant_q.size()) ? grant_q[i] : 9, i % 2);
    repeat (6) @(negedge CLK);
    chk("contention_rsp0", rsp_n0 - r0, 3);
    chk("contention_rsp1", rsp_n1 - r1, 3);

    // Reset in the middle of a write pulse
    req0_write = 1'b1; req0_addr = 18'h00055; req0_wdata = 16'h5555; req0_be = 2'b11;
    req0_valid = 1'b1;
    a0 = acc0;
    for (int c = 0; c < 20 && acc0 == a0; c++) @(negedge CLK);
    req0_valid = 1'b0;
    chk("rstwr_accept", acc0 - a0, 1);
    for (int c = 0; c < 10 && sram_we_n; c++) @(negedge CLK);
    chk("rstwr_in_pulse", int'(sram_we_n), 0);
    #2 RESET = 1'b1;
    #1;
    chk("rstwr_we_n", int'(sram_we_n), 1);
    chk("rstwr_ce_n", int'(sram_ce_n), 1);
    chk("rstwr_drive", int'(sram_drive), 0);
    chk("rstwr_addr", int'(sram_addr), 0);
    req0_valid = 1'b1;
    #1 chk("rstwr_ready_in_reset", int'(req0_ready), 0);
    req0_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    chk("rstwr_prio", int'(dut.r_prio), 0);
    chk("rstwr_idle", int'(sram_ce_n), 1);
    run_op(1'b0, 1'b0, 18'h00123, 16'h0000, 2'b11, 16'hBEEF);

    // Port 1 only: random reads and writes against a reference memory
    for (int i = 0; i < 8; i++) begin
      raddr[i] = {3'(i), 15'($urandom)};
      refm[i]  = 16'($urandom);
      run_op(1'b1, 1'b1, raddr[i], refm[i], 2'b11, 16'h0000);
    end
    p_exp = int'(dut.r_prio);
    for (int n = 0; n < 10; n++) begin
      slot = int'($urandom_range(0, 7));
      wr   = 1'($urandom);
      if (wr) begin
        d  = 16'($urandom);
        be = 2'($urandom);
        run_op(1'b1, 1'b1, raddr[slot], d, be, 16'h0000);
        if (be[0]) refm[slot][7:0]  = d[7:0];
        if (be[1]) refm[slot][15:8] = d[15:8];
      end else begin
        run_op(1'b1, 1'b0, raddr[slot], 16'h0000, 2'b11, refm[slot]);
      end
      p_exp = 1 - p_exp;
      chk("rand_prio_toggle", int'(dut.r_prio), p_exp);
    end
    for (int i = 0; i < 8; i++)
      run_op(1'b1, 1'b0, raddr[i], 16'h0000, 2'b11, refm[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and cycle sequencer for the board's external asynchronous 16-bit SRAM. It sits between the generated design logic and the SRAM pads: it grants one requester at a time and drives the address bus, CE/WE/OE/LB/UB strobes and the data-pad tristate enable for the SB_IO array. It generates write setup/pulse/hold phases and read wait states, then returns read data with a one-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 18, SRAM word-address width
- RD_WAIT, 2, cycles OE is held low before read data is sampled (min 1)
- WR_PULSE, 2, cycles WE is held low (min 1)

Ports:
- CLK  in  1  single clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-high reset
- reqN_valid  in  1  (N = 0,1) request pending
- reqN_ready  out  1  request accepted this cycle when reqN_valid & reqN_ready
- reqN_write  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_W  word address
- reqN_wdata  in  16  write data
- reqN_be  in  2  byte enables, [0] = low byte, [1] = high byte
- rspN_valid  out  1  one-cycle pulse: read data valid
- rspN_rdata  out  16  read data, held until the next read response on that port
- sram_addr  out  ADDR_W  SRAM address, registered
- sram_dout  out  16  to SB_IO D_OUT_0, registered
- sram_drive  out  1  to SB_IO OUTPUT_ENABLE, registered
- sram_din  in  16  from SB_IO D_IN_0 (unregistered pad input)
- sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n  out  1 each  active-low strobes, registered

## Operation
- States: IDLE, RD, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE: all strobes high, sram_drive=0. ready is combinational: reqN_ready=1 only in IDLE, not during RESET, and only for the granted port.
- Grant is round-robin. If only one port is valid, that port is granted. If both are valid, grant goes to port `prio`. After every accept, `prio` becomes the other port. Reset value of `prio` is 0.
- On accept: latch addr, wdata and be, plus the granted port ID. sram_lb_n = ~be[0], sram_ub_n = ~be[1], sram_ce_n = 0 for the whole operation.
- Read: RD lasts RD_WAIT cycles with oe_n=0. sram_din is captured into rspN_rdata at the edge that leaves the last RD cycle. RD_DONE lasts 1 cycle with oe_n=1, ce_n=0 and rspN_valid=1 for the latched port. The FSM then returns to IDLE.
- Write: WR_SETUP lasts 1 cycle with drive=1, we_n=1. WR_PULSE lasts WR_PULSE cycles with we_n=0. WR_HOLD lasts 1 cycle with we_n=1, drive=1 and address/data unchanged. The FSM then returns to IDLE. Writes produce no response.
- be=2'b00 is still sequenced in full, with both lb_n/ub_n high. No bytes change.
- Invariants:
  - oe_n=0 and drive=1 never occur in the same cycle.
  - we_n=0 only when drive=1.
  - Address and byte enables are stable from the first non-IDLE cycle to the last.
- Address and data are not checked. Addresses wrap naturally within ADDR_W.

## Timing
- Reset values: all *_n outputs = 1, sram_drive=0, sram_addr=0, sram_dout=0, rspN_valid=0, rspN_rdata=0, reqN_ready=0, state=IDLE, prio=0.
- Accept occurs at edge T0.
  - Read: oe_n low for cycles T0+1 .. T0+RD_WAIT; rspN_valid high in cycle T0+RD_WAIT+1. The next accept is possible at edge T0+RD_WAIT+2, so back-to-back reads take RD_WAIT+2 cycles each.
  - Write: we_n low for cycles T0+2 .. T0+WR_PULSE+1; next accept at edge T0+WR_PULSE+3.
- Turnaround: RD_DONE and IDLE together guarantee at least 2 cycles with drive=0 and oe_n=1 between a read's OE and a following write's data drive.
- A request that deasserts valid before being granted is dropped with no side effect. Requesters must hold valid and payload stable until ready.
- RESET mid-operation: all outputs go to their reset values asynchronously. An in-flight write may corrupt the target word. An in-flight read produces no response.

## Test plan
- Single read, RD_WAIT=2: req0 read addr 0x00123, sram_din model returns 0xBEEF. Required: oe_n low exactly 2 cycles, rsp0_valid is a 1-cycle pulse 3 cycles after accept, rsp0_rdata=0xBEEF.
- Single write, WR_PULSE=2: req1 write addr 0x3FFFF, data 0xA55A, be=2'b01. Required: WR_SETUP 1 cycle, we_n low 2 cycles, lb_n=0, ub_n=1, drive=1 for 4 cycles, no rsp1_valid pulse.
- Contention: both ports hold valid for 6 operations. Required: grants alternate 0,1,0,1,0,1, and no port waits more than one other operation.
- Read then write back-to-back on port 0. Required: at least 2 cycles with oe_n=1 and drive=0 between the last oe_n=0 cycle and the first drive=1 cycle; the checker flags any oe_n=0 & drive=1 overlap.
- RESET asserted during WR_PULSE. Required: we_n=1, ce_n=1 and drive=0 in the same cycle, without waiting for an edge. After release, the FSM is in IDLE, prio=0, and a new read completes normally.
- Port 1 only with 10 random reads and writes against an SRAM model. Required: all read data match the model, and prio toggles after each accept.
